// File: rtl/wb_write_queue.sv
// Writeback queue driving the register-file write port, with two forwarding lookup ports.
// Define WBQ_STATS_EN to add the retired-write and stalled-head counters (stat_wr/stat_stall).
module wb_write_queue #(
    parameter int RegAddrBus = 5,
    parameter int RegBus     = 32,
    parameter int Depth      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wreg,
    input  logic [RegAddrBus-1:0] in_waddr,
    input  logic [RegBus-1:0]     in_wdata,
    input  logic                  flush,
    input  logic                  wb_stall,
    output logic                  wen,
    output logic [RegAddrBus-1:0] waddr,
    output logic [RegBus-1:0]     wdata,
    input  logic [RegAddrBus-1:0] q_addr1,
    output logic                  q_hit1,
    output logic [RegBus-1:0]     q_data1,
    input  logic [RegAddrBus-1:0] q_addr2,
    output logic                  q_hit2,
    output logic [RegBus-1:0]     q_data2
`ifdef WBQ_STATS_EN
    ,
    output logic [31:0]           stat_wr,
    output logic [31:0]           stat_stall
`endif
);

    localparam int PtrW = $clog2(Depth);
    localparam int NumPorts = 2;

    logic [RegAddrBus-1:0] addr_q [Depth];
    logic [RegBus-1:0]     data_q [Depth];
    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic [PtrW:0]         count_q, count_d;

    logic head_valid;
    logic push_fire;
    logic store;
    logic pop;

    assign head_valid = (count_q != '0);
    assign in_ready   = (count_q < (PtrW+1)'(Depth));
    assign push_fire  = in_valid && in_ready && !flush;
    // Results that never touch the register file are acknowledged but not queued.
    assign store      = push_fire && in_wreg && (in_waddr != '0);
    assign wen        = head_valid && !wb_stall && !flush;
    assign pop        = wen;
    assign waddr      = wen ? addr_q[head_q] : '0;
    assign wdata      = wen ? data_q[head_q] : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)
                head_d = head_q + 1'b1;
            if (store)
                tail_d = tail_q + 1'b1;
            if (store && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !store)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: only slots inside [head, head+count) are ever read.
    always_ff @(posedge clk) begin
        if (store) begin
            addr_q[tail_q] <= in_waddr;
            data_q[tail_q] <= in_wdata;
        end
    end

    // Walk from oldest to youngest so the last match found is the youngest one.
    function automatic logic [RegBus:0] lookup(input logic [RegAddrBus-1:0] a);
        logic [RegBus:0] r;
        logic [PtrW-1:0] idx;
        r = '0;
        for (int k = 0; k < Depth; k++) begin
            idx = head_q + PtrW'(k);
            if (((PtrW+1)'(k) < count_q) && (a != '0) && (addr_q[idx] == a))
                r = {1'b1, data_q[idx]};
        end
        return r;
    endfunction

    logic [RegAddrBus-1:0] lk_addr [NumPorts];
    logic [RegBus:0]       lk_res  [NumPorts];

    assign lk_addr[0] = q_addr1;
    assign lk_addr[1] = q_addr2;

    generate
        for (genvar gi = 0; gi < NumPorts; gi++) begin : g_lookup
            always_comb begin
                lk_res[gi] = lookup(lk_addr[gi]);
            end
        end
    endgenerate

    assign q_hit1  = lk_res[0][RegBus];
    assign q_data1 = lk_res[0][RegBus-1:0];
    assign q_hit2  = lk_res[1][RegBus];
    assign q_data2 = lk_res[1][RegBus-1:0];

`ifdef WBQ_STATS_EN
    logic [31:0] stat_wr_q, stat_wr_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Counters survive flush; only reset clears them.
    always_comb begin
        stat_wr_d    = stat_wr_q;
        stat_stall_d = stat_stall_q;
        if (wen)
            stat_wr_d = stat_wr_q + 32'd1;
        if (head_valid && wb_stall)
            stat_stall_d = stat_stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_wr_q    <= stat_wr_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_wr    = stat_wr_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule
